// File: rtl/camerica_pkg.sv
// Shared definitions for the video-memory fetch path: FSM encoding, kind
// encoding, default job sizes and the address packing helper.
package camerica_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_t;

   localparam logic KIND_LINE  = 1'b0;
   localparam logic KIND_HISTO = 1'b1;

   localparam int DEF_LINE_WORDS  = 256;
   localparam int DEF_HISTO_WORDS = 256;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 64;

   // Address layout: {memory select, bank, word index}.
   function automatic logic [ADDR_W-1:0] vm_addr(input logic kind, input logic bank,
                                                 input logic [7:0] idx);
      return {kind, bank, idx};
   endfunction

endpackage

// File: rtl/vm_read_port.sv
// Single-outstanding read port towards video memory: raises the request strobe
// with a frozen address, drops it on acknowledge and forces one idle cycle after.
module vm_read_port
   import camerica_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              done,
   output logic [DATA_W-1:0] done_data,
   output logic              vm_bus_enable,
   output logic              vm_rw,
   output logic [ADDR_W-1:0] vm_address,
   input  logic              vm_acknowledge,
   input  logic [DATA_W-1:0] vm_read_data
);

   logic              bus_en_q;
   logic              gap_q;
   logic [ADDR_W-1:0] addr_q;

   // Handshake: a request is open while bus_en_q is high; it closes on the
   // first cycle vm_acknowledge is seen, and gap_q blocks reopening next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus_en_q <= 1'b0;
         gap_q    <= 1'b0;
         addr_q   <= '0;
      end else begin
         gap_q <= 1'b0;
         if (bus_en_q) begin
            if (vm_acknowledge) begin
               bus_en_q <= 1'b0;
               gap_q    <= 1'b1;
            end
         end else if (req && !gap_q) begin
            bus_en_q <= 1'b1;
            addr_q   <= req_addr;
         end
      end
   end

   assign done          = bus_en_q & vm_acknowledge;
   assign done_data     = vm_read_data;
   assign vm_bus_enable = bus_en_q;
   assign vm_rw         = bus_en_q;
   assign vm_address    = addr_q;

endmodule

// File: rtl/vm_fetcher.sv
// Turns bank-completion toggles into sequential read jobs over video memory
// and streams the words out through a valid/ready port.
module vm_fetcher
   import camerica_pkg::*;
#(
   parameter int LINE_WORDS  = DEF_LINE_WORDS,
   parameter int HISTO_WORDS = DEF_HISTO_WORDS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              status_which_line,
   input  logic              status_which_histo,
   output logic              vm_bus_enable,
   output logic              vm_rw,
   output logic [ADDR_W-1:0] vm_address,
   input  logic              vm_acknowledge,
   input  logic [DATA_W-1:0] vm_read_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_kind,
   output logic              out_first,
   output logic              out_last,
   output logic [7:0]        overrun_count
);

   localparam logic [7:0] LINE_LAST  = 8'(LINE_WORDS - 1);
   localparam logic [7:0] HISTO_LAST = 8'(HISTO_WORDS - 1);

   fetch_state_t state, state_next;

   logic              line_copy, histo_copy;
   logic              line_tog, histo_tog;
   logic              line_pend, histo_pend;
   logic              line_pend_bank, histo_pend_bank;
   logic              job_kind, job_bank;
   logic [7:0]        job_idx;
   logic [7:0]        last_idx;
   logic              start_line, start_histo, capture, accept;
   logic              line_active, histo_active;
   logic              line_ovr, histo_ovr;
   logic [8:0]        ovr_sum;
   logic [7:0]        ovr_next;
   logic              rd_done;
   logic [DATA_W-1:0] rd_data;

   assign line_tog  = status_which_line ^ line_copy;
   assign histo_tog = status_which_histo ^ histo_copy;

   assign line_active  = (state != ST_IDLE) && (job_kind == KIND_LINE);
   assign histo_active = (state != ST_IDLE) && (job_kind == KIND_HISTO);

   // A new completion while the same kind is still queued or running loses data.
   assign line_ovr  = enable && line_tog && (line_pend || line_active);
   assign histo_ovr = enable && histo_tog && (histo_pend || histo_active);

   assign ovr_sum  = {1'b0, overrun_count} + 9'(line_ovr) + 9'(histo_ovr);
   assign ovr_next = (ovr_sum > 9'd255) ? 8'hFF : ovr_sum[7:0];

   assign last_idx = (job_kind == KIND_HISTO) ? HISTO_LAST : LINE_LAST;

   always_comb begin
      state_next  = state;
      start_line  = 1'b0;
      start_histo = 1'b0;
      capture     = 1'b0;
      accept      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (line_pend) begin
               start_line = 1'b1;
               state_next = ST_REQ;
            end else if (histo_pend) begin
               start_histo = 1'b1;
               state_next  = ST_REQ;
            end
         end
         ST_REQ: begin
            if (rd_done) begin
               capture    = 1'b1;
               state_next = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (out_valid && out_ready) begin
               accept     = 1'b1;
               state_next = out_last ? ST_IDLE : ST_REQ;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // Copies follow the inputs so a reset never looks like a completion.
         line_copy       <= status_which_line;
         histo_copy      <= status_which_histo;
         line_pend       <= 1'b0;
         histo_pend      <= 1'b0;
         line_pend_bank  <= 1'b0;
         histo_pend_bank <= 1'b0;
         job_kind        <= KIND_LINE;
         job_bank        <= 1'b0;
         job_idx         <= 8'd0;
         out_valid       <= 1'b0;
         out_data        <= '0;
         out_kind        <= KIND_LINE;
         out_first       <= 1'b0;
         out_last        <= 1'b0;
         overrun_count   <= 8'd0;
      end else begin
         line_copy     <= status_which_line;
         histo_copy    <= status_which_histo;
         overrun_count <= ovr_next;

         if (enable && line_tog) begin
            line_pend      <= 1'b1;
            line_pend_bank <= line_copy;
         end else if (start_line) begin
            line_pend <= 1'b0;
         end

         if (enable && histo_tog) begin
            histo_pend      <= 1'b1;
            histo_pend_bank <= histo_copy;
         end else if (start_histo) begin
            histo_pend <= 1'b0;
         end

         if (start_line) begin
            job_kind <= KIND_LINE;
            job_bank <= line_pend_bank;
            job_idx  <= 8'd0;
         end else if (start_histo) begin
            job_kind <= KIND_HISTO;
            job_bank <= histo_pend_bank;
            job_idx  <= 8'd0;
         end

         if (capture) begin
            out_valid <= 1'b1;
            out_data  <= rd_data;
            out_kind  <= job_kind;
            out_first <= (job_idx == 8'd0);
            out_last  <= (job_idx == last_idx);
         end else if (accept) begin
            out_valid <= 1'b0;
            if (!out_last) begin
               job_idx <= job_idx + 8'd1;
            end
         end
      end
   end

   vm_read_port u_read_port (
      .clk            (clk),
      .rst            (rst),
      .req            (state == ST_REQ),
      .req_addr       (vm_addr(job_kind, job_bank, job_idx)),
      .done           (rd_done),
      .done_data      (rd_data),
      .vm_bus_enable  (vm_bus_enable),
      .vm_rw          (vm_rw),
      .vm_address     (vm_address),
      .vm_acknowledge (vm_acknowledge),
      .vm_read_data   (vm_read_data)
   );

endmodule

// File: tb/tb_vm_fetcher.sv
// Randomised scoreboard bench for vm_fetcher: a memory responder, a decoupled
// output monitor, and directed scenarios built on a job-level expectation model.
module tb_vm_fetcher;

   localparam int STALL_LEN = 10;

   logic        clk = 1'b0;
   logic        rst, enable, sl, sh;
   logic        bus_en, rw, ack, ready, valid, kind, first, last;
   logic [9:0]  addr;
   logic [63:0] rdata, odata;
   logic [7:0]  ovr;

   logic        sl1, sh1, bus_en1, rw1, ack1, ready1, valid1, kind1, first1, last1;
   logic [9:0]  addr1;
   logic [63:0] rdata1, odata1;
   logic [7:0]  ovr1;

   logic [63:0] mem [1024];
   logic [66:0] exp_q[$];
   logic [66:0] exp1_q[$];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int exp_ovr = 0;

   int lat_max = 0;
   int ready_pct = 100;
   bit check_spacing = 1'b0;
   int last_rise = -1;
   int acc_count = 0;
   int stall_at = -1;
   int stall_left = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   vm_fetcher u_dut (
      .clk(clk), .rst(rst), .enable(enable),
      .status_which_line(sl), .status_which_histo(sh),
      .vm_bus_enable(bus_en), .vm_rw(rw), .vm_address(addr),
      .vm_acknowledge(ack), .vm_read_data(rdata),
      .out_valid(valid), .out_ready(ready), .out_data(odata),
      .out_kind(kind), .out_first(first), .out_last(last),
      .overrun_count(ovr)
   );

   vm_fetcher #(.LINE_WORDS(1), .HISTO_WORDS(2)) u_one (
      .clk(clk), .rst(rst), .enable(1'b1),
      .status_which_line(sl1), .status_which_histo(sh1),
      .vm_bus_enable(bus_en1), .vm_rw(rw1), .vm_address(addr1),
      .vm_acknowledge(ack1), .vm_read_data(rdata1),
      .out_valid(valid1), .out_ready(ready1), .out_data(odata1),
      .out_kind(kind1), .out_first(first1), .out_last(last1),
      .overrun_count(ovr1)
   );

   task automatic check(input string name, input logic [66:0] got, input logic [66:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Expected stream of one job: word i of bank b of kind k, first/last tags.
   task automatic push_job(input bit which, input logic k, input logic b, input int n);
      logic [7:0]  ix;
      logic [66:0] item;
      for (int i = 0; i < n; i++) begin
         ix   = i[7:0];
         item = {mem[{k, b, ix}], k, (i == 0), (i == n - 1)};
         if (which) exp1_q.push_back(item);
         else exp_q.push_back(item);
      end
   endtask

   task automatic toggle(input bit l, input bit h, output logic old_l, output logic old_h);
      @(negedge clk);
      old_l = sl;
      old_h = sh;
      if (l) sl = ~sl;
      if (h) sh = ~sh;
   endtask

   task automatic add_ovr(input int n);
      exp_ovr = (exp_ovr + n > 255) ? 255 : exp_ovr + n;
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s timeout words_left=%0d want=0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_acc(input int target, input string name);
      int n = 0;
      while (acc_count < target && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (acc_count < target) begin
         total++;
         bad++;
         $display("FAIL %s timeout accepted=%0d want=%0d", name, acc_count, target);
      end
   endtask

   task automatic quiet(input int n, input string name);
      logic seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         seen = seen | bus_en | valid;
      end
      check(name, seen, 0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_valid"}, valid, 0);
      check({tag, "_bus"}, bus_en, 0);
      check({tag, "_rw"}, rw, 0);
      check({tag, "_addr"}, addr, 0);
      check({tag, "_tags"}, {kind, first, last}, 0);
      check({tag, "_data"}, odata, 0);
      check({tag, "_ovr"}, ovr, 0);
   endtask

   // Memory responder for the main DUT, with handshake property checks.
   initial begin
      logic prev_en = 1'b0, prev_ack = 1'b0;
      logic [9:0] prev_addr = '0;
      int wait_cnt = 0;
      ack = 1'b0;
      rdata = '0;
      forever begin
         @(negedge clk);
         if (prev_en && prev_ack) check("bus_gap", bus_en, 0);
         if (prev_en && !prev_ack && bus_en) check("addr_stable", addr, prev_addr);
         if (bus_en) check("rw_follows_en", rw, 1);
         ack = 1'b0;
         if (bus_en && !prev_en) begin
            wait_cnt = $urandom_range(0, lat_max);
            if (check_spacing && last_rise >= 0) check("req_spacing", cyc - last_rise, 3);
            last_rise = cyc;
         end
         if (bus_en) begin
            if (wait_cnt == 0) begin
               ack   = 1'b1;
               rdata = mem[addr];
            end else begin
               wait_cnt--;
               rdata = {$urandom, $urandom};
            end
         end
         prev_en   = bus_en;
         prev_ack  = ack;
         prev_addr = addr;
      end
   end

   // Output monitor: chooses out_ready, then scores the word that will be taken.
   initial begin
      logic [63:0] stall_data = '0;
      logic [66:0] want;
      ready = 1'b0;
      forever begin
         @(negedge clk);
         if (valid && acc_count == stall_at && stall_left > 0) begin
            if (stall_left == STALL_LEN) stall_data = odata;
            else check("stall_data", odata, stall_data);
            check("stall_bus_low", bus_en, 0);
            ready = 1'b0;
            stall_left--;
         end else begin
            ready = ($urandom_range(1, 100) <= ready_pct);
         end
         if (valid && ready) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_word got=%h want=none", odata);
            end else begin
               want = exp_q.pop_front();
               check("word", {odata, kind, first, last}, want);
            end
            acc_count++;
         end
      end
   end

   // Responder and monitor for the small-job DUT.
   initial begin
      ack1 = 1'b0;
      rdata1 = '0;
      ready1 = 1'b1;
      forever begin
         @(negedge clk);
         ack1   = bus_en1;
         rdata1 = mem[addr1];
         if (valid1) begin
            if (exp1_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_small_word got=%h want=none", odata1);
            end else begin
               check("small_word", {odata1, kind1, first1, last1}, exp1_q.pop_front());
            end
         end
      end
   end

   initial begin
      #800000;
      bad++;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      logic ol, oh, b_last;
      int base;
      for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
      rst = 1'b1;
      enable = 1'b1;
      sl = 1'b0;
      sh = 1'b1;
      sl1 = 1'b0;
      sh1 = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_values("rst_init");
      rst = 1'b0;
      quiet(20, "no_job_after_reset");

      // Single line job, unthrottled: addresses 0x000.., 3 cycles per request.
      check_spacing = 1'b1;
      last_rise = -1;
      toggle(1, 0, ol, oh);
      push_job(0, 0, ol, 256);
      drain(3000, "s1_line");
      check_spacing = 1'b0;

      // Both kinds at once: line first, then histogram; random latency/ready.
      lat_max = 2;
      ready_pct = 70;
      toggle(1, 1, ol, oh);
      push_job(0, 0, ol, 256);
      push_job(0, 1, oh, 256);
      drain(8000, "s2_both");

      // Consumer stall on word 5.
      lat_max = 0;
      ready_pct = 100;
      stall_at = acc_count + 5;
      stall_left = STALL_LEN;
      toggle(1, 0, ol, oh);
      push_job(0, 0, ol, 256);
      drain(4000, "s3_stall");
      check("stall_consumed", stall_left, 0);

      // Two extra line completions during an active line job.
      toggle(1, 0, ol, oh);
      push_job(0, 0, ol, 256);
      base = acc_count;
      wait_acc(base + 10, "s4_progress");
      toggle(1, 0, ol, oh);
      repeat (4) @(negedge clk);
      toggle(1, 0, b_last, oh);
      push_job(0, 0, b_last, 256);
      add_ovr(2);
      repeat (2) @(negedge clk);
      check("s4_overrun", ovr, exp_ovr);
      drain(8000, "s4_jobs");
      check("s4_overrun_after", ovr, exp_ovr);

      // Toggles with enable low are ignored entirely.
      enable = 1'b0;
      toggle(1, 1, ol, oh);
      repeat (5) @(negedge clk);
      enable = 1'b1;
      quiet(30, "s6_disabled_quiet");
      check("s6_overrun", ovr, exp_ovr);

      // Overrun saturation: histogram toggles every cycle during a histogram job.
      toggle(0, 1, ol, oh);
      push_job(0, 1, oh, 256);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 300; i++) toggle(0, 1, ol, b_last);
      push_job(0, 1, b_last, 256);
      add_ovr(300);
      repeat (2) @(negedge clk);
      check("s7_overrun_sat", ovr, exp_ovr);
      drain(8000, "s7_jobs");

      // Reset while requesting word 40.
      toggle(1, 0, ol, oh);
      push_job(0, 0, ol, 256);
      base = acc_count;
      wait_acc(base + 40, "s5_progress");
      @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      check_reset_values("rst_mid");
      exp_ovr = 0;
      quiet(40, "s5_quiet");

      // Randomised jobs with random enable, latency and back-pressure.
      for (int it = 0; it < 6; it++) begin
         int r;
         bit en;
         r = $urandom_range(1, 3);
         en = ($urandom_range(0, 3) != 0);
         lat_max = $urandom_range(0, 3);
         ready_pct = $urandom_range(40, 100);
         enable = en;
         toggle(r[0], r[1], ol, oh);
         if (en && r[0]) push_job(0, 0, ol, 256);
         if (en && r[1]) push_job(0, 1, oh, 256);
         repeat (3) @(negedge clk);
         enable = ($urandom_range(0, 1) == 1);
         drain(9000, "rand_jobs");
         enable = 1'b1;
         quiet(10, "rand_quiet");
         check("rand_overrun", ovr, exp_ovr);
      end

      // One-word line jobs and two-word histogram jobs on the small instance.
      toggle(0, 0, ol, oh);
      ol = sl1;
      sl1 = ~sl1;
      push_job(1, 0, ol, 1);
      repeat (10) @(negedge clk);
      oh = sh1;
      sh1 = ~sh1;
      push_job(1, 1, oh, 2);
      repeat (20) @(negedge clk);
      check("small_drained", exp1_q.size(), 0);
      check("small_overrun", ovr1, 0);

      check("main_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
